fpu_addsub_ctrl: RTL and testbench

Pipelined issue/retire controller for the single-precision add/subtract datapath. It sits between the FPU decode/dispatch logic and the combinational `fp_add_sub` unit. It accepts one operation per cycle over a valid/ready handshake and resolves the dynamic rounding mode against the `frm` CSR. It registers operands into the adder and registers the adder's result into an output stage with backpressure, tag return and flush.

---
 rtl/fpu_addsub_ctrl_pkg.sv | 25 ++
 rtl/fpu_addsub_ctrl_fp_add_sub.sv | 106 ++++++++++
 rtl/fpu_addsub_ctrl.sv | 137 +++++++++++++
 tb/tb_fpu_addsub_ctrl.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/fpu_addsub_ctrl_pkg.sv
//==============================================================================
// Module      : fpu_addsub_ctrl_pkg
// Description : Shared FPU constants: canonical NaN and rounding-mode codes.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

package fpu_addsub_ctrl_pkg;

   localparam logic [31:0] FP_CANON_NAN = 32'h7FC0_0000;
   localparam logic [2:0]  RM_DYN       = 3'b111;

   localparam logic [2:0]  RNE = 3'd0;
   localparam logic [2:0]  RTZ = 3'd1;
   localparam logic [2:0]  RDN = 3'd2;
   localparam logic [2:0]  RUP = 3'd3;
   localparam logic [2:0]  RMM = 3'd4;

   function automatic logic rm_is_illegal(input logic [2:0] rm);
      return rm > RMM;
   endfunction

endpackage

`default_nettype wire

// File: rtl/fpu_addsub_ctrl_fp_add_sub.sv
//==============================================================================
// Module      : fp_add_sub
// Description : Combinational IEEE-754 single-precision adder/subtractor.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module fp_add_sub
   import fpu_addsub_ctrl_pkg::*;
(
   input  logic [31:0] Num_A,
   input  logic [31:0] Num_B,
   input  logic        A_S,
   input  logic [2:0]  R_M,
   output logic [31:0] Result
);

   logic        w_sa, w_sb, w_sl, w_eff_sub, w_swap;
   logic        w_a_nan, w_b_nan, w_a_inf, w_b_inf, w_nan;
   logic [7:0]  w_xa, w_xb, w_d;
   logic [4:0]  w_dc, w_lz, w_nsh;
   logic [23:0] w_ma, w_mb, w_ml, w_ms, w_mant;
   logic [49:0] w_shifted;
   logic [26:0] w_al, w_as, w_norm;
   logic [27:0] w_sum;
   logic [9:0]  w_exp;
   logic [24:0] w_rnd;
   logic        w_rb, w_st, w_inc;

   always_comb begin
      w_sa      = Num_A[31];
      w_sb      = Num_B[31] ^ A_S;
      w_eff_sub = w_sa ^ w_sb;
      w_a_nan   = (Num_A[30:23] == 8'hFF) && (Num_A[22:0] != 23'd0);
      w_b_nan   = (Num_B[30:23] == 8'hFF) && (Num_B[22:0] != 23'd0);
      w_a_inf   = (Num_A[30:23] == 8'hFF) && (Num_A[22:0] == 23'd0);
      w_b_inf   = (Num_B[30:23] == 8'hFF) && (Num_B[22:0] == 23'd0);
      w_nan     = w_a_nan | w_b_nan | (w_a_inf & w_b_inf & w_eff_sub);

      // Subnormals share the exponent of the smallest normal, minus the hidden bit.
      w_xa = (Num_A[30:23] == 8'd0) ? 8'd1 : Num_A[30:23];
      w_xb = (Num_B[30:23] == 8'd0) ? 8'd1 : Num_B[30:23];
      w_ma = {|Num_A[30:23], Num_A[22:0]};
      w_mb = {|Num_B[30:23], Num_B[22:0]};

      w_swap = Num_B[30:0] > Num_A[30:0];
      w_sl   = w_swap ? w_sb : w_sa;
      w_ml   = w_swap ? w_mb : w_ma;
      w_ms   = w_swap ? w_ma : w_mb;
      w_exp  = {2'b00, (w_swap ? w_xb : w_xa)};
      w_d    = w_swap ? (w_xb - w_xa) : (w_xa - w_xb);
      w_dc   = (w_d > 8'd26) ? 5'd26 : w_d[4:0];

      // Aligned smaller operand: 24-bit mantissa, guard, round, sticky.
      w_shifted = {w_ms, 26'd0} >> w_dc;
      w_as      = {w_shifted[49:24], |w_shifted[23:0]};
      w_al      = {w_ml, 3'b000};
      w_sum     = w_eff_sub ? ({1'b0, w_al} - {1'b0, w_as}) : ({1'b0, w_al} + {1'b0, w_as});

      w_lz  = 5'd26;
      w_nsh = 5'd0;
      if (w_sum[27]) begin
         w_norm = {w_sum[27:2], w_sum[1] | w_sum[0]};
         w_exp  = w_exp + 10'd1;
      end else begin
         for (int i = 0; i < 27; i++) begin
            if (w_sum[i]) w_lz = 5'(26 - i);
         end
         // Never normalise below the minimum exponent; the rest stays subnormal.
         w_nsh  = ({5'd0, w_lz} > (w_exp - 10'd1)) ? 5'(w_exp - 10'd1) : w_lz;
         w_norm = w_sum[26:0] << w_nsh;
         w_exp  = w_exp - {5'd0, w_nsh};
      end

      w_rb = w_norm[2];
      w_st = |w_norm[1:0];
      case (R_M)
         RTZ:     w_inc = 1'b0;
         RDN:     w_inc = (w_rb | w_st) & w_sl;
         RUP:     w_inc = (w_rb | w_st) & ~w_sl;
         RMM:     w_inc = w_rb;
         default: w_inc = w_rb & (w_st | w_norm[3]);
      endcase
      w_rnd  = {1'b0, w_norm[26:3]} + {24'd0, w_inc};
      w_mant = w_rnd[23:0];
      if (w_rnd[24]) begin
         w_mant = 24'h80_0000;
         w_exp  = w_exp + 10'd1;
      end

      if (w_nan)
         Result = FP_CANON_NAN;
      else if (w_a_inf | w_b_inf)
         Result = {(w_a_inf ? w_sa : w_sb), 8'hFF, 23'd0};
      else if (w_sum == 28'd0)
         Result = {(w_eff_sub ? (R_M == RDN) : w_sa), 31'd0};
      else if (w_exp >= 10'd255)
         Result = ((R_M == RTZ) || ((R_M == RDN) && !w_sl) || ((R_M == RUP) && w_sl))
                  ? {w_sl, 31'h7F7F_FFFF} : {w_sl, 8'hFF, 23'd0};
      else
         Result = {w_sl, (w_mant[23] ? w_exp[7:0] : 8'h00), w_mant[22:0]};
   end

endmodule

`default_nettype wire

// File: rtl/fpu_addsub_ctrl.sv
//==============================================================================
// Module      : fpu_addsub_ctrl
// Description : Two-stage issue/retire controller around fp_add_sub with
//               backpressure, flush and retire counting. Optional rounding-mode
//               legality check enabled by FPU_RM_CHECK_EN.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module fpu_addsub_ctrl
   import fpu_addsub_ctrl_pkg::*;
#(
   parameter int TAG_W = 5
)
(
   input  logic             clk,
   input  logic             rst,
   input  logic             flush,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [31:0]      in_a,
   input  logic [31:0]      in_b,
   input  logic             in_op,
   input  logic [2:0]       in_rm,
   input  logic [TAG_W-1:0] in_tag,
   input  logic [2:0]       frm,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [31:0]      out_result,
   output logic [TAG_W-1:0] out_tag,
   output logic             out_illegal,
   output logic             busy,
   output logic [15:0]      retired
);

   logic             r_s1_valid, r_s2_valid;
   logic [31:0]      r_s1_a, r_s1_b, r_s2_result;
   logic             r_s1_op;
   logic [2:0]       r_s1_rm;
   logic [TAG_W-1:0] r_s1_tag, r_s2_tag;
   logic [15:0]      r_retired;
   logic             w_s2_free, w_s1_adv, w_accept;
   logic [2:0]       w_rm;
   logic [31:0]      w_sum, w_s2_next;

   assign w_s2_free = !r_s2_valid | out_ready;
   assign w_s1_adv  = r_s1_valid & w_s2_free;
   assign in_ready  = !flush & (!r_s1_valid | w_s1_adv);
   assign w_accept  = in_valid & in_ready;
   assign w_rm      = (in_rm == RM_DYN) ? frm : in_rm;

   fp_add_sub u_fp_add_sub (
      .Num_A  (r_s1_a),
      .Num_B  (r_s1_b),
      .A_S    (r_s1_op),
      .R_M    (r_s1_rm),
      .Result (w_sum)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_s1_valid <= 1'b0;
         r_s2_valid <= 1'b0;
      end else if (flush) begin
         r_s1_valid <= 1'b0;
         r_s2_valid <= 1'b0;
      end else begin
         if (w_accept)      r_s1_valid <= 1'b1;
         else if (w_s1_adv) r_s1_valid <= 1'b0;
         if (w_s1_adv)       r_s2_valid <= 1'b1;
         else if (out_ready) r_s2_valid <= 1'b0;
      end
   end

   // Rounding mode is frozen at accept so later frm writes cannot reach it.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_s1_a   <= '0;
         r_s1_b   <= '0;
         r_s1_op  <= 1'b0;
         r_s1_rm  <= '0;
         r_s1_tag <= '0;
      end else if (w_accept) begin
         r_s1_a   <= in_a;
         r_s1_b   <= in_b;
         r_s1_op  <= in_op;
         r_s1_rm  <= w_rm;
         r_s1_tag <= in_tag;
      end
   end

`ifdef FPU_RM_CHECK_EN
   logic r_s1_illegal, r_s2_illegal;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_s1_illegal <= 1'b0;
         r_s2_illegal <= 1'b0;
      end else begin
         if (w_accept) r_s1_illegal <= rm_is_illegal(w_rm);
         if (w_s1_adv) r_s2_illegal <= r_s1_illegal;
      end
   end

   assign w_s2_next   = r_s1_illegal ? FP_CANON_NAN : w_sum;
   assign out_illegal = r_s2_illegal;
`else
   assign w_s2_next   = w_sum;
   assign out_illegal = 1'b0;
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_s2_result <= '0;
         r_s2_tag    <= '0;
      end else if (w_s1_adv) begin
         r_s2_result <= w_s2_next;
         r_s2_tag    <= r_s1_tag;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         r_retired <= '0;
      else if (r_s2_valid & out_ready)
         r_retired <= r_retired + 16'd1;
   end

   assign out_valid  = r_s2_valid;
   assign out_result = r_s2_result;
   assign out_tag    = r_s2_tag;
   assign busy       = r_s1_valid | r_s2_valid;
   assign retired    = r_retired;

endmodule

`default_nettype wire

// File: tb/tb_fpu_addsub_ctrl.sv
//==============================================================================
// Module      : tb_fpu_addsub_ctrl
// Description : Self-checking bench for fpu_addsub_ctrl (table vectors plus
//               backpressure, flush, illegal-rm and reset sequences).
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_fpu_addsub_ctrl;
   import fpu_addsub_ctrl_pkg::*;

   localparam int TAG_W = 5;

   logic             clk = 1'b0;
   logic             rst, flush, in_valid, in_ready, in_op, out_valid, out_ready;
   logic             out_illegal, busy;
   logic [31:0]      in_a, in_b, out_result;
   logic [2:0]       in_rm, frm;
   logic [TAG_W-1:0] in_tag, out_tag;
   logic [15:0]      retired;

   int          n_checks = 0;
   int          n_errors = 0;
   logic [15:0] exp_retired = 16'd0;

   always #5 clk = ~clk;

   fpu_addsub_ctrl #(.TAG_W(TAG_W)) dut (
      .clk(clk), .rst(rst), .flush(flush),
      .in_valid(in_valid), .in_ready(in_ready),
      .in_a(in_a), .in_b(in_b), .in_op(in_op), .in_rm(in_rm), .in_tag(in_tag),
      .frm(frm),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_result(out_result), .out_tag(out_tag), .out_illegal(out_illegal),
      .busy(busy), .retired(retired)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      n_checks++;
      if (act !== req) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", name, act, req);
      end
   endtask

   typedef struct {
      logic [31:0] a;
      logic [31:0] b;
      logic        op;
      logic [2:0]  rm;
      logic [2:0]  frm;
      logic [4:0]  tag;
      logic [31:0] res;
   } vec_t;

   vec_t vecs[9];

   task automatic present(input logic [31:0] a, input logic [31:0] b, input logic op,
                          input logic [2:0] rm, input logic [4:0] tag);
      in_a = a; in_b = b; in_op = op; in_rm = rm; in_tag = tag; in_valid = 1'b1;
   endtask

   // One isolated operation; inputs and frm are scrambled right after accept.
   task automatic run_vec(input vec_t v);
      @(negedge clk);
      frm = v.frm;
      out_ready = 1'b1;
      present(v.a, v.b, v.op, v.rm, v.tag);
      #1 chk("vec_in_ready", {31'd0, in_ready}, 32'd1);
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      in_a = ~v.a;
      in_b = ~v.b;
      frm = (v.frm == 3'd0) ? 3'd1 : 3'd0;
      @(negedge clk);
      chk("vec_early_valid", {31'd0, out_valid}, 32'd0);
      chk("vec_busy", {31'd0, busy}, 32'd1);
      @(negedge clk);
      chk("vec_out_valid", {31'd0, out_valid}, 32'd1);
      chk("vec_result", out_result, v.res);
      chk("vec_tag", {27'd0, out_tag}, {27'd0, v.tag});
      chk("vec_illegal", {31'd0, out_illegal}, 32'd0);
      exp_retired++;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int got;
      logic [4:0] exp_tags [3];

      vecs[0] = '{32'h3F80_0000, 32'h4000_0000, 1'b0, 3'd0, 3'd0, 5'd3, 32'h4040_0000};
      vecs[1] = '{32'h4040_0000, 32'h3F80_0000, 1'b1, 3'd0, 3'd0, 5'd4, 32'h4000_0000};
      vecs[2] = '{32'h3F80_0000, 32'h33C0_0000, 1'b0, 3'd7, 3'd1, 5'd5, 32'h3F80_0000};
      vecs[3] = '{32'h3F80_0000, 32'h33C0_0000, 1'b0, 3'd7, 3'd0, 5'd6, 32'h3F80_0001};
      vecs[4] = '{32'h3F80_0000, 32'h33C0_0000, 1'b0, 3'd1, 3'd0, 5'd7, 32'h3F80_0000};
      vecs[5] = '{32'h3FC0_0000, 32'hBFC0_0000, 1'b0, 3'd0, 3'd0, 5'd8, 32'h0000_0000};
      vecs[6] = '{32'h4000_0000, 32'h3F00_0000, 1'b1, 3'd0, 3'd0, 5'd9, 32'h3FC0_0000};
      vecs[7] = '{32'h3F80_0000, 32'h3380_0000, 1'b0, 3'd3, 3'd0, 5'd10, 32'h3F80_0001};
      vecs[8] = '{32'h3F80_0000, 32'h3380_0000, 1'b0, 3'd0, 3'd0, 5'd11, 32'h3F80_0000};

      rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
      in_a = '0; in_b = '0; in_op = 1'b0; in_rm = '0; in_tag = '0; frm = '0;
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
      #1;
      chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
      chk("rst_result", out_result, 32'd0);
      chk("rst_tag", {27'd0, out_tag}, 32'd0);
      chk("rst_illegal", {31'd0, out_illegal}, 32'd0);
      chk("rst_busy", {31'd0, busy}, 32'd0);
      chk("rst_retired", {16'd0, retired}, 32'd0);
      chk("rst_in_ready", {31'd0, in_ready}, 32'd1);

      for (int i = 0; i < 9; i++) run_vec(vecs[i]);
      @(negedge clk);
      chk("vec_retired", {16'd0, retired}, {16'd0, exp_retired});

      // Illegal rounding mode
      present(32'h3F80_0000, 32'h4000_0000, 1'b0, 3'd5, 5'd12);
      @(posedge clk);
      #1 in_valid = 1'b0;
      @(negedge clk);
      @(negedge clk);
      chk("ill_out_valid", {31'd0, out_valid}, 32'd1);
`ifdef FPU_RM_CHECK_EN
      chk("ill_flag", {31'd0, out_illegal}, 32'd1);
      chk("ill_result", out_result, FP_CANON_NAN);
`else
      chk("ill_flag", {31'd0, out_illegal}, 32'd0);
      chk("ill_result", out_result, 32'h4040_0000);
`endif
      exp_retired++;

      // Backpressure: tags 1 and 2 fill the pipe, tag 3 waits
      @(negedge clk);
      out_ready = 1'b0;
      present(32'h3F80_0000, 32'h4000_0000, 1'b0, 3'd0, 5'd1);
      #1 chk("bp_ready1", {31'd0, in_ready}, 32'd1);
      @(negedge clk);
      in_tag = 5'd2;
      #1 chk("bp_ready2", {31'd0, in_ready}, 32'd1);
      @(negedge clk);
      in_tag = 5'd3;
      #1 chk("bp_full_ready", {31'd0, in_ready}, 32'd0);
      chk("bp_head_tag", {27'd0, out_tag}, 32'd1);
      @(negedge clk);
      in_a = 32'hDEAD_BEEF;
      #1 chk("bp_hold_ready", {31'd0, in_ready}, 32'd0);
      chk("bp_hold_tag", {27'd0, out_tag}, 32'd1);
      chk("bp_hold_result", out_result, 32'h4040_0000);
      in_a = 32'h3F80_0000;
      out_ready = 1'b1;
      #1 chk("bp_release_ready", {31'd0, in_ready}, 32'd1);
      exp_tags[0] = 5'd1; exp_tags[1] = 5'd2; exp_tags[2] = 5'd3;
      got = 1;
      @(posedge clk);
      #1 in_valid = 1'b0;
      for (int c = 0; c < 8 && got < 3; c++) begin
         @(negedge clk);
         if (out_valid) begin
            chk("bp_order_tag", {27'd0, out_tag}, {27'd0, exp_tags[got]});
            chk("bp_busy", {31'd0, busy}, 32'd1);
            got++;
         end
      end
      chk("bp_count", got, 32'd3);
      exp_retired = exp_retired + 16'd3;
      @(negedge clk);
      chk("bp_drained", {31'd0, out_valid}, 32'd0);
      chk("bp_retired", {16'd0, retired}, {16'd0, exp_retired});

      // Flush with two in flight, an input presented and an output taken
      out_ready = 1'b0;
      present(32'h3F80_0000, 32'h4000_0000, 1'b0, 3'd0, 5'd8);
      @(negedge clk);
      in_tag = 5'd9;
      @(negedge clk);
      chk("fl_busy_pre", {31'd0, busy}, 32'd1);
      flush = 1'b1;
      out_ready = 1'b1;
      in_tag = 5'd10;
      #1 chk("fl_in_ready", {31'd0, in_ready}, 32'd0);
      exp_retired++;
      @(posedge clk);
      #1 flush = 1'b0; in_valid = 1'b0;
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         chk("fl_out_valid", {31'd0, out_valid}, 32'd0);
         chk("fl_busy", {31'd0, busy}, 32'd0);
      end
      chk("fl_retired", {16'd0, retired}, {16'd0, exp_retired});

      // Asynchronous reset mid-stream
      out_ready = 1'b0;
      present(32'h3F80_0000, 32'h4000_0000, 1'b0, 3'd0, 5'd11);
      @(posedge clk);
      #1 in_valid = 1'b0;
      @(negedge clk);
      @(negedge clk);
      chk("ar_pre_valid", {31'd0, out_valid}, 32'd1);
      #2 rst = 1'b1;
      #1;
      chk("ar_out_valid", {31'd0, out_valid}, 32'd0);
      chk("ar_result", out_result, 32'd0);
      chk("ar_tag", {27'd0, out_tag}, 32'd0);
      chk("ar_busy", {31'd0, busy}, 32'd0);
      chk("ar_retired", {16'd0, retired}, 32'd0);
      exp_retired = 16'd0;
      @(negedge clk);
      rst = 1'b0;
      #1 chk("ar_in_ready", {31'd0, in_ready}, 32'd1);
      run_vec(vecs[1]);
      @(negedge clk);
      chk("ar_post_retired", {16'd0, retired}, {16'd0, exp_retired});

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

`default_nettype wire
